// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding and one-hot helper for the UART TX arbiter.
package uart_tx_arb_pkg;
    localparam int STATE_SIZE = 2;
    localparam logic [STATE_SIZE-1:0] IDLE = 2'd0;
    localparam logic [STATE_SIZE-1:0] LOCKED = 2'd1;
    localparam logic [STATE_SIZE-1:0] HOLDOFF = 2'd2;
    typedef enum logic [STATE_SIZE-1:0] {
        ST_IDLE = IDLE,
        ST_LOCKED = LOCKED,
        ST_HOLDOFF = HOLDOFF
    } state_t;
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 8; i++) if (oh[i]) oh2idx = 3'(i);
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester side and UART side signals of the TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_ack;
    logic [NUM_REQ-1:0] grant;
    logic busy;
    logic new_data_tx;
    logic [DATA_WIDTH-1:0] data_tx;
    modport master (
        input req, req_data, req_last, busy,
        output req_ack, grant, new_data_tx, data_tx
    );
    modport slave (
        output req, req_data, req_last, busy,
        input req_ack, grant, new_data_tx, data_tx
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational winner search after ptr; UART_TX_ARB_FIXED_PRIO_EN picks lowest index instead.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input logic [NUM_REQ-1:0] req,
    input logic [PW-1:0] ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PW-1:0] idx
);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (req[k]) win = NUM_REQ'(1) << k;
    end
`else
    // Scan farthest-first so the nearest set bit after ptr overwrites the rest
    always_comb begin
        win = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) win = NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ);
    end
`endif
    assign idx = PW'(oh2idx(8'(win)));
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART TX among NUM_REQ producers.
// Define UART_TX_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST = 32
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.master bus
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    state_t state, state_n;
    logic [NUM_REQ-1:0] win, grant_n, ack_n;
    logic [PW-1:0] rr_ptr, ptr_n, win_idx, own, own_n;
    logic [CW-1:0] burst_cnt, cnt_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic strobe_n, rel, rel_n;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req(bus.req),
        .ptr(rr_ptr),
        .win(win),
        .idx(win_idx)
    );

    always_comb begin
        state_n = state;
        grant_n = bus.grant;
        ack_n = '0;
        strobe_n = 1'b0;
        data_n = bus.data_tx;
        cnt_n = burst_cnt;
        ptr_n = rr_ptr;
        own_n = own;
        rel_n = rel;
        case (state)
            ST_IDLE: if (|bus.req) begin
                grant_n = win;
                own_n = win_idx;
                cnt_n = '0;
                state_n = ST_LOCKED;
            end
            ST_LOCKED: if (!bus.req[own]) begin
                grant_n = '0;
                ptr_n = own;
                state_n = ST_IDLE;
            end else if (!bus.busy) begin
                strobe_n = 1'b1;
                data_n = bus.req_data[own*DATA_WIDTH +: DATA_WIDTH];
                ack_n = bus.grant;
                cnt_n = burst_cnt + 1'b1;
                rel_n = bus.req_last[own] || burst_cnt == CW'(MAX_BURST - 1);
                state_n = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                grant_n = rel ? '0 : bus.grant;
                ptr_n = rel ? own : rr_ptr;
                state_n = rel ? ST_IDLE : ST_LOCKED;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= ST_IDLE;
            bus.grant <= '0;
            bus.req_ack <= '0;
            bus.new_data_tx <= 1'b0;
            bus.data_tx <= '0;
            burst_cnt <= '0;
            rr_ptr <= PW'(NUM_REQ - 1);
            own <= '0;
            rel <= 1'b0;
        end else begin
            state <= state_n;
            bus.grant <= grant_n;
            bus.req_ack <= ack_n;
            bus.new_data_tx <= strobe_n;
            bus.data_tx <= data_n;
            burst_cnt <= cnt_n;
            rr_ptr <= ptr_n;
            own <= own_n;
            rel <= rel_n;
        end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (busy / new-data strobe / 8-bit data) among NUM_REQ byte producers, e.g. the host command responder and a telemetry streamer.
- Round-robin grant with packet lock: a granted requester keeps the transmitter until it marks its last byte or hits MAX_BURST.
- Sits between the requesting controllers and the UART TX core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, byte width on every data path.
- MAX_BURST, 32, bytes per grant before a forced release (1..255).

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  asynchronous, active-low reset: asserts immediately when low, released synchronously to clk.
- req  input  NUM_REQ  per-requester request; level, held until its byte is acked.
- req_data  input  NUM_REQ*DATA_WIDTH  byte for requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the presented byte as the last of the packet.
- req_ack  output  NUM_REQ  one-cycle pulse: the presented byte was accepted.
- grant  output  NUM_REQ  one-hot current owner; zero when idle.
- busy  input  1  UART TX busy.
- new_data_tx  output  1  one-cycle send strobe to the UART.
- data_tx  output  DATA_WIDTH  byte to the UART; valid while new_data_tx is high.

Behaviour:
- Reset values:
  - grant=0, req_ack=0, new_data_tx=0, data_tx=0, burst_cnt=0.
  - State = IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, LOCKED, HOLDOFF.
- IDLE:
  - new_data_tx=0, req_ack=0.
  - If any req bit is set: winner = first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - On a win: grant <= onehot(winner), burst_cnt <= 0, go LOCKED. Otherwise stay.
- LOCKED, owner g:
  - If req[g]=0, the requester abandoned the packet: grant <= 0, rr_ptr <= g, go IDLE.
  - Else if busy=0:
    - new_data_tx <= 1, data_tx <= req_data[g], req_ack[g] <= 1, burst_cnt <= burst_cnt+1.
    - release <= req_last[g] OR (burst_cnt == MAX_BURST-1).
    - Go HOLDOFF.
  - Else (busy=1): wait in LOCKED; strobe stays low.
- HOLDOFF:
  - Exactly one cycle; new_data_tx <= 0, req_ack <= 0, giving the UART a cycle to raise busy.
  - If release: grant <= 0, rr_ptr <= g, go IDLE. Else go LOCKED.
- Latency and throughput:
  - req rise to new_data_tx high = 2 cycles, with busy low.
  - Inside a burst, at most one byte every 2 cycles.
  - Re-arbitration after a release costs 1 idle cycle.
- Strobe: new_data_tx is never high on two consecutive cycles, and is never high while grant is 0.
- Requester handshake:
  - A requester changes req_data/req_last only in the cycle after its req_ack.
  - Deasserting req while not owner has no effect.
- Width:
  - burst_cnt is $clog2(MAX_BURST+1) bits; it never wraps, being cleared on every grant.
  - rr_ptr is $clog2(NUM_REQ) bits (min 1); the wrap search is modulo NUM_REQ.
- Simultaneous requests: all set -> rotation 0,1,...,NUM_REQ-1,0; a non-requesting index is skipped.
- MAX_BURST=1 degenerates to byte-level round-robin.
- busy stuck high: stays in LOCKED indefinitely; no timeout.
- Reset mid-burst: all outputs return to reset values asynchronously. A partially sent packet is not resumed; the requester re-requests.

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index set req bit, rr_ptr is unused and optimised away, and packet lock and MAX_BURST release behave as above.
- Undefined: round-robin as specified.

Decomposition:
- Shared package uart_tx_arb_pkg holds:
  - the state encoding localparams (IDLE=0, LOCKED=1, HOLDOFF=2, STATE_SIZE=2);
  - a one-hot-to-index helper function.
- One sub-module, rr_pick:
  - combinational: req vector and rr_ptr in, one-hot winner plus index out;
  - the macro selects fixed priority inside it.
- FSM, counters and output registers live in uart_tx_arbiter.

Test Plan:
1. Reset: hold rst low with req=2'b11 -> grant=0, new_data_tx=0, req_ack=0. Release rst -> grant=2'b01 one cycle later and new_data_tx one cycle after that, carrying req_data[0].
2. Burst lock:
   - Stimulus: req0 sends 0x41,0x42,0x43, last on 0x43, with req1 held high throughout and busy low.
   - Response: data_tx sequence 0x41,0x42,0x43 with strobes 2 cycles apart.
   - Then grant=2'b10 and req1's byte follows.
3. Round-robin wrap: NUM_REQ=3, all req high, single-byte packets -> grant order 0,1,2,0,1.
4. busy backpressure: hold busy high for 10 cycles while LOCKED -> no strobe and no ack. busy low -> strobe on the next edge.
5. MAX_BURST=4: req0 never asserts last while req1 waits -> exactly 4 bytes from req0, then grant moves to req1.
6. Abandon and reset:
   - req0 drops mid-packet -> grant=0 next cycle, req1 is served next.
   - Separately, drive rst low mid-burst -> outputs clear immediately and no stray strobe appears after release.
